// File: rtl/jtsdram_ba0_arb_if.sv
// Requester-side and SDRAM bank-0 signals handled by jtsdram_ba0_arb.
// The arbiter takes the slave view; requesters together with the controller take the master view.
interface jtsdram_ba0_arb_if #(
  parameter int NREQ = 3,
  parameter int AW   = 22
);
  logic [NREQ-1:0]      req_rd;
  logic [NREQ-1:0]      req_wr;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*16-1:0]   req_din;
  logic [NREQ*2-1:0]    req_din_m;
  logic [NREQ-1:0]      req_ack;
  logic [NREQ-1:0]      req_rdy;
  logic                 req_err;
  logic [15:0]          req_dout;

  logic [AW-1:0]        ba0_addr;
  logic                 ba0_rd;
  logic                 ba0_wr;
  logic [15:0]          ba0_din;
  logic [1:0]           ba0_din_m;
  logic                 ba0_ack;
  logic                 ba0_rdy;
  logic [31:0]          data_read;

  modport slave (
    input  req_rd, req_wr, req_addr, req_din, req_din_m,
    output req_ack, req_rdy, req_err, req_dout,
    output ba0_addr, ba0_rd, ba0_wr, ba0_din, ba0_din_m,
    input  ba0_ack, ba0_rdy, data_read
  );

  modport master (
    output req_rd, req_wr, req_addr, req_din, req_din_m,
    input  req_ack, req_rdy, req_err, req_dout,
    input  ba0_addr, ba0_rd, ba0_wr, ba0_din, ba0_din_m,
    output ba0_ack, ba0_rdy, data_read
  );
endinterface

// File: rtl/jtsdram_ba0_arb.sv
// Round-robin arbiter sharing the SDRAM bank-0 port among NREQ requesters, one
// rd/wr -> ack -> rdy transaction at a time, with a watchdog on each handshake phase.
module jtsdram_ba0_arb #(
  parameter int NREQ = 3,
  parameter int AW   = 22,
  parameter int TOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  jtsdram_ba0_arb_if.slave bus,
  output logic             busy,
  output logic             tout_flag
);
  localparam int PW = (NREQ > 2) ? 2 : 1;
  localparam int SW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t          state_r, state_nx;
  logic [PW-1:0]   ptr_r, g_r, gsel_s;
  logic [7:0]      cnt_r;
  logic            wr_r, err_pend_r;
  logic [NREQ-1:0] act_s;
  logic            any_s, tout_hit_s;
  logic            ld_s, clr_stb_s, ack_p_s, rdy_p_s, cap_s;
  logic            cnt_clr_s, cnt_inc_s, abort_s;

  logic [NREQ-1:0] req_ack_r, req_rdy_r;
  logic            req_err_r;
  logic [15:0]     req_dout_r;
  logic [AW-1:0]   ba0_addr_r;
  logic            ba0_rd_r, ba0_wr_r;
  logic [15:0]     ba0_din_r;
  logic [1:0]      ba0_din_m_r;
  logic            busy_r, tout_flag_r;
  logic            unused_s;

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = {NREQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  assign unused_s   = ^bus.data_read[31:16];
  assign tout_hit_s = (cnt_r == 8'(TOUT));

  // Rotating priority: the active requester closest to ptr_r (in scan order) wins.
  always_comb begin
    logic [SW-1:0] sum_v;
    logic [PW-1:0] idx_v;
    act_s  = bus.req_rd | bus.req_wr;
    any_s  = |act_s;
    gsel_s = ptr_r;
    for (int i = NREQ - 1; i >= 0; i--) begin
      sum_v  = {1'b0, ptr_r} + SW'(i);
      sum_v  = (sum_v >= SW'(NREQ)) ? (sum_v - SW'(NREQ)) : sum_v;
      idx_v  = sum_v[PW-1:0];
      gsel_s = act_s[idx_v] ? idx_v : gsel_s;
    end
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_nx  = state_r;
    ld_s      = 1'b0;
    clr_stb_s = 1'b0;
    ack_p_s   = 1'b0;
    rdy_p_s   = 1'b0;
    cap_s     = 1'b0;
    cnt_clr_s = 1'b0;
    cnt_inc_s = 1'b0;
    abort_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (any_s) begin
          ld_s      = 1'b1;
          cnt_clr_s = 1'b1;
          state_nx  = ST_REQ;
        end else begin
          state_nx  = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.ba0_ack) begin
          clr_stb_s = 1'b1;
          ack_p_s   = 1'b1;
          cnt_clr_s = 1'b1;
          if (bus.ba0_rdy) begin
            // Ack and rdy together: the transaction is already finished.
            cap_s    = 1'b1;
            state_nx = ST_DONE;
          end else begin
            state_nx = ST_WAIT;
          end
        end else if (tout_hit_s) begin
          clr_stb_s = 1'b1;
          abort_s   = 1'b1;
          state_nx  = ST_DONE;
        end else begin
          cnt_inc_s = 1'b1;
        end
      end
      ST_WAIT: begin
        if (bus.ba0_rdy) begin
          cap_s     = 1'b1;
          state_nx  = ST_DONE;
        end else if (tout_hit_s) begin
          clr_stb_s = 1'b1;
          abort_s   = 1'b1;
          state_nx  = ST_DONE;
        end else begin
          cnt_inc_s = 1'b1;
        end
      end
      ST_DONE: begin
        rdy_p_s  = 1'b1;
        state_nx = ST_IDLE;
      end
      default: begin
        clr_stb_s = 1'b1;
        state_nx  = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Grant latch and bank-0 bus; address/data/mask hold their last value when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_r         <= {PW{1'b0}};
      wr_r        <= 1'b0;
      ba0_addr_r  <= {AW{1'b0}};
      ba0_din_r   <= 16'h0000;
      ba0_din_m_r <= 2'b00;
      ba0_rd_r    <= 1'b0;
      ba0_wr_r    <= 1'b0;
    end else if (ld_s) begin
      g_r         <= gsel_s;
      wr_r        <= bus.req_wr[gsel_s];
      ba0_addr_r  <= bus.req_addr[gsel_s*AW +: AW];
      ba0_din_r   <= bus.req_din[gsel_s*16 +: 16];
      ba0_din_m_r <= bus.req_din_m[gsel_s*2 +: 2];
      ba0_rd_r    <= ~bus.req_wr[gsel_s];
      ba0_wr_r    <= bus.req_wr[gsel_s];
    end else if (clr_stb_s) begin
      ba0_rd_r    <= 1'b0;
      ba0_wr_r    <= 1'b0;
    end
  end

  // Watchdog counter, round-robin pointer and sticky/pending error state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r       <= 8'd0;
      ptr_r       <= {PW{1'b0}};
      err_pend_r  <= 1'b0;
      tout_flag_r <= 1'b0;
    end else begin
      if (cnt_clr_s) begin
        cnt_r <= 8'd0;
      end else if (cnt_inc_s) begin
        cnt_r <= cnt_r + 8'd1;
      end
      if (rdy_p_s) begin
        ptr_r <= (g_r == PW'(NREQ - 1)) ? {PW{1'b0}} : (g_r + PW'(1));
      end
      if (ld_s) begin
        err_pend_r <= 1'b0;
      end else if (abort_s) begin
        err_pend_r <= 1'b1;
      end
      tout_flag_r <= tout_flag_r | abort_s;
    end
  end

  // Requester-facing pulses, read data and busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ack_r  <= {NREQ{1'b0}};
      req_rdy_r  <= {NREQ{1'b0}};
      req_err_r  <= 1'b0;
      req_dout_r <= 16'h0000;
      busy_r     <= 1'b0;
    end else begin
      req_ack_r <= ack_p_s ? onehot(g_r) : {NREQ{1'b0}};
      req_rdy_r <= rdy_p_s ? onehot(g_r) : {NREQ{1'b0}};
      req_err_r <= rdy_p_s & err_pend_r;
      if (cap_s && !wr_r) begin
        req_dout_r <= bus.data_read[15:0];
      end
      busy_r <= (state_nx != ST_IDLE);
    end
  end

  assign bus.req_ack   = req_ack_r;
  assign bus.req_rdy   = req_rdy_r;
  assign bus.req_err   = req_err_r;
  assign bus.req_dout  = req_dout_r;
  assign bus.ba0_addr  = ba0_addr_r;
  assign bus.ba0_rd    = ba0_rd_r;
  assign bus.ba0_wr    = ba0_wr_r;
  assign bus.ba0_din   = ba0_din_r;
  assign bus.ba0_din_m = ba0_din_m_r;
  assign busy          = busy_r;
  assign tout_flag     = tout_flag_r;
endmodule

// File: tb/tb_jtsdram_ba0_arb.sv
// Directed bench for jtsdram_ba0_arb: a small SDRAM-controller responder plus
// per-test requester stimulus, all expectations written by hand.
module tb_jtsdram_ba0_arb;
  localparam int NREQ = 3;
  localparam int AW   = 22;
  localparam int TOUT = 255;

  logic clk, rst_n, busy, tout_flag;
  int   n_cmp, n_bad, cyc;

  bit          ack_en;
  int          ack_lat, rdy_lat, phase, pn, rdy_drv_cyc;
  logic [15:0] rdata;

  int stb_rd_cnt, stb_wr_cnt, rdy_cyc, gcnt;
  int ack_cnt [NREQ];
  int rdy_cnt [NREQ];
  int glog [64];

  jtsdram_ba0_arb_if #(.NREQ(NREQ), .AW(AW)) bus ();

  jtsdram_ba0_arb #(.NREQ(NREQ), .AW(AW), .TOUT(TOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .tout_flag (tout_flag)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor first (DUT outputs), then the controller responder drives ack/rdy.
  always @(negedge clk) begin
    if (bus.ba0_rd === 1'b1) stb_rd_cnt++;
    if (bus.ba0_wr === 1'b1) stb_wr_cnt++;
    for (int k = 0; k < NREQ; k++) begin
      if (bus.req_ack[k] === 1'b1) begin
        ack_cnt[k]++;
        if (gcnt < 64) glog[gcnt] = k;
        gcnt++;
      end
      if (bus.req_rdy[k] === 1'b1) begin
        rdy_cnt[k]++;
        rdy_cyc = cyc;
      end
    end
    bus.ba0_ack   = 1'b0;
    bus.ba0_rdy   = 1'b0;
    bus.data_read = {16'hDEAD, rdata};
    if (!rst_n) begin
      phase = 0;
      pn    = 0;
    end else begin
      if (phase == 0 && (bus.ba0_rd | bus.ba0_wr) === 1'b1) begin
        phase = 1;
        pn    = 0;
      end
      if (phase == 1) begin
        if ((bus.ba0_rd | bus.ba0_wr) !== 1'b1) begin
          phase = 0;
        end else begin
          pn++;
          if (ack_en && pn == ack_lat) begin
            bus.ba0_ack = 1'b1;
            if (rdy_lat == 0) begin
              bus.ba0_rdy = 1'b1;
              rdy_drv_cyc = cyc;
              phase       = 0;
            end else begin
              phase = 2;
              pn    = 0;
            end
          end
        end
      end else if (phase == 2) begin
        pn++;
        if (pn == rdy_lat) begin
          bus.ba0_rdy = 1'b1;
          rdy_drv_cyc = cyc;
          phase       = 0;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rdy(input int k, input int budget, input string tag);
    int n;
    n = 0;
    while (bus.req_rdy[k] !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check_eq(tag, 32'(bus.req_rdy[k]), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    check_eq(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    int s_stb, s_ack, s_rdy, base, n;
    rst_n         = 1'b0;
    bus.req_rd    = '0;
    bus.req_wr    = '0;
    bus.req_addr  = '0;
    bus.req_din   = '0;
    bus.req_din_m = '0;
    ack_en  = 1'b1;
    ack_lat = 3;
    rdy_lat = 3;
    rdata   = 16'hBEEF;
    repeat (3) step();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_strobes", 32'({bus.ba0_rd, bus.ba0_wr}), 32'd0);
    check_eq("rst_pulses", 32'({bus.req_ack, bus.req_rdy, bus.req_err}), 32'd0);
    check_eq("rst_dout", 32'(bus.req_dout), 32'd0);
    check_eq("rst_tout", 32'(tout_flag), 32'd0);
    rst_n = 1'b1;
    step();

    // Single read by requester 0: ack after 3 strobe cycles, rdy 3 cycles later.
    s_stb = stb_rd_cnt; s_ack = ack_cnt[0]; s_rdy = rdy_cnt[0];
    bus.req_addr[0*AW +: AW] = 22'h12345;
    bus.req_rd[0] = 1'b1;
    wait_rdy(0, 40, "rd0_done");
    check_eq("rd0_err", 32'(bus.req_err), 32'd0);
    check_eq("rd0_dout", 32'(bus.req_dout), 32'h0000BEEF);
    check_eq("rd0_latency", 32'(rdy_cyc - rdy_drv_cyc), 32'd2);
    bus.req_rd[0] = 1'b0;
    wait_idle(10, "rd0_idle");
    step(); step();
    check_eq("rd0_stb_cycles", 32'(stb_rd_cnt - s_stb), 32'd3);
    check_eq("rd0_ack_pulses", 32'(ack_cnt[0] - s_ack), 32'd1);
    check_eq("rd0_rdy_pulses", 32'(rdy_cnt[0] - s_rdy), 32'd1);
    check_eq("rd0_no_regrant", 32'(busy), 32'd0);
    check_eq("rd0_addr_hold", 32'(bus.ba0_addr), 32'h00012345);

    // Write by requester 1; read data register must keep 0xBEEF.
    ack_lat = 2; rdy_lat = 2; rdata = 16'h1234;
    bus.req_addr[1*AW +: AW] = 22'h3ABCD;
    bus.req_din[16 +: 16]    = 16'hA55A;
    bus.req_din_m[2 +: 2]    = 2'b01;
    bus.req_wr[1] = 1'b1;
    step();
    check_eq("wr1_strobes", 32'({bus.ba0_rd, bus.ba0_wr}), 32'd1);
    check_eq("wr1_din", 32'(bus.ba0_din), 32'h0000A55A);
    check_eq("wr1_mask", 32'(bus.ba0_din_m), 32'd1);
    check_eq("wr1_addr", 32'(bus.ba0_addr), 32'h0003ABCD);
    wait_rdy(1, 40, "wr1_done");
    check_eq("wr1_err", 32'(bus.req_err), 32'd0);
    check_eq("wr1_dout_kept", 32'(bus.req_dout), 32'h0000BEEF);
    bus.req_wr[1] = 1'b0;
    wait_idle(10, "wr1_idle");

    // Requester 2 asserts rd and wr; ack and rdy arrive together.
    ack_lat = 2; rdy_lat = 0;
    s_ack = ack_cnt[2]; s_rdy = rdy_cnt[2];
    bus.req_rd[2] = 1'b1;
    bus.req_wr[2] = 1'b1;
    step();
    check_eq("both_is_write", 32'({bus.ba0_rd, bus.ba0_wr}), 32'd1);
    wait_rdy(2, 40, "same_done");
    check_eq("same_err", 32'(bus.req_err), 32'd0);
    bus.req_rd[2] = 1'b0;
    bus.req_wr[2] = 1'b0;
    wait_idle(10, "same_idle");
    step(); step(); step();
    check_eq("same_ack_pulses", 32'(ack_cnt[2] - s_ack), 32'd1);
    check_eq("same_rdy_pulses", 32'(rdy_cnt[2] - s_rdy), 32'd1);
    // Next grant still proceeds (lone requester 2 re-granted).
    ack_lat = 1; rdy_lat = 1; rdata = 16'h5A5A;
    bus.req_rd[2] = 1'b1;
    wait_rdy(2, 40, "next_done");
    check_eq("next_dout", 32'(bus.req_dout), 32'h00005A5A);
    bus.req_rd[2] = 1'b0;
    wait_idle(10, "next_idle");

    // All requesters continuously active: strict rotation from ptr 0.
    base = gcnt;
    bus.req_rd = 3'b111;
    n = 0;
    while ((gcnt - base) < 6 && n < 300) begin
      step();
      n++;
    end
    check_eq("rr_six_grants", 32'((gcnt - base) >= 6), 32'd1);
    bus.req_rd = 3'b000;
    wait_idle(40, "rr_idle");
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("rr_grant_%0d", i), 32'(glog[base + i]), 32'(i % 3));
    end

    // Watchdog: ack never arrives.
    ack_en = 1'b0;
    s_stb = stb_rd_cnt;
    bus.req_rd[1] = 1'b1;
    wait_rdy(1, 400, "to_done");
    check_eq("to_err", 32'(bus.req_err), 32'd1);
    check_eq("to_flag", 32'(tout_flag), 32'd1);
    check_eq("to_stb_cycles", 32'(stb_rd_cnt - s_stb), 32'(TOUT + 1));
    bus.req_rd[1] = 1'b0;
    wait_idle(10, "to_idle");
    ack_en = 1'b1; ack_lat = 1; rdy_lat = 1; rdata = 16'h0F0F;
    bus.req_rd[0] = 1'b1;
    wait_rdy(0, 40, "after_to_done");
    check_eq("after_to_err", 32'(bus.req_err), 32'd0);
    check_eq("after_to_dout", 32'(bus.req_dout), 32'h00000F0F);
    check_eq("to_flag_sticky", 32'(tout_flag), 32'd1);
    bus.req_rd[0] = 1'b0;
    wait_idle(10, "after_to_idle");

    // Reset while in WAIT with ptr at 1; afterwards requester 0 must win over 2.
    ack_lat = 1; rdy_lat = 30;
    s_ack = ack_cnt[2];
    bus.req_rd[2] = 1'b1;
    n = 0;
    while (ack_cnt[2] == s_ack && n < 20) begin
      step();
      n++;
    end
    check_eq("rs_ack_seen", 32'(ack_cnt[2] - s_ack), 32'd1);
    step(); step();
    check_eq("rs_in_wait_busy", 32'(busy), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check_eq("rs_strobes", 32'({bus.ba0_rd, bus.ba0_wr}), 32'd0);
    check_eq("rs_busy", 32'(busy), 32'd0);
    check_eq("rs_rdy", 32'(bus.req_rdy), 32'd0);
    check_eq("rs_tout_clear", 32'(tout_flag), 32'd0);
    rdy_lat = 2;
    bus.req_rd[0] = 1'b1;
    step(); step();
    rst_n = 1'b1;
    base = gcnt;
    n = 0;
    while (gcnt == base && n < 20) begin
      step();
      n++;
    end
    check_eq("rs_first_grant", 32'(glog[base]), 32'd0);
    wait_rdy(0, 40, "rs_req0_done");
    bus.req_rd[0] = 1'b0;
    wait_rdy(2, 40, "rs_req2_done");
    bus.req_rd[2] = 1'b0;
    wait_idle(10, "rs_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
